// File: rtl/arch_event_arbiter.sv
// Round-robin arbiter plus one-entry output register sharing a single difftest arch-event port.
// Optional interrupt-first arbitration is enabled by defining ARCH_EVENT_INT_PRIO_EN.
module arch_event_arbiter #(
    parameter int NUM_SRC = 2,
    parameter int PTR_W   = 3
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NUM_SRC-1:0]      src_valid,
    output logic [NUM_SRC-1:0]      src_ready,
    input  logic [32*NUM_SRC-1:0]   src_interrupt,
    input  logic [32*NUM_SRC-1:0]   src_exception,
    input  logic [64*NUM_SRC-1:0]   src_exception_pc,
    input  logic [32*NUM_SRC-1:0]   src_exception_inst,
    input  logic [8*NUM_SRC-1:0]    src_coreid,
    input  logic                    sink_stall,
    output logic                    out_enable,
    output logic [31:0]             out_interrupt,
    output logic [31:0]             out_exception,
    output logic [63:0]             out_exception_pc,
    output logic [31:0]             out_exception_inst,
    output logic [7:0]              out_coreid,
    output logic [31:0]             evt_count
);

    logic                ovld_reg;
    logic [PTR_W-1:0]    rr_ptr_reg;
    logic [31:0]         evt_count_reg;
    logic [31:0]         interrupt_reg;
    logic [31:0]         exception_reg;
    logic [63:0]         exception_pc_reg;
    logic [31:0]         exception_inst_reg;
    logic [7:0]          coreid_reg;

    logic                ld_ok;
    logic                handshake;
    logic                found;
    logic [NUM_SRC-1:0]  cand;
    logic [NUM_SRC-1:0]  grant;
    logic [PTR_W-1:0]    rr_ptr_next;

    logic [31:0]         int_arr  [NUM_SRC];
    logic [31:0]         exc_arr  [NUM_SRC];
    logic [63:0]         pc_arr   [NUM_SRC];
    logic [31:0]         inst_arr [NUM_SRC];
    logic [7:0]          core_arr [NUM_SRC];

    logic [31:0]         int_next;
    logic [31:0]         exc_next;
    logic [63:0]         pc_next;
    logic [31:0]         inst_next;
    logic [7:0]          core_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign int_arr[gi]  = src_interrupt[32*gi +: 32];
            assign exc_arr[gi]  = src_exception[32*gi +: 32];
            assign pc_arr[gi]   = src_exception_pc[64*gi +: 64];
            assign inst_arr[gi] = src_exception_inst[32*gi +: 32];
            assign core_arr[gi] = src_coreid[8*gi +: 8];
        end
    endgenerate

`ifdef ARCH_EVENT_INT_PRIO_EN
    logic [NUM_SRC-1:0] int_qual;

    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_qual
            assign int_qual[gi] = src_valid[gi] & (|int_arr[gi]);
        end
    endgenerate

    // Interrupt-carrying sources win; otherwise fall back to all valid sources.
    assign cand = (|int_qual) ? int_qual : src_valid;
`else
    assign cand = src_valid;
`endif

    function automatic int wrap_idx(input int base, input int k);
        int s;
        s = base + k;
        if (s >= NUM_SRC) begin
            s = s - NUM_SRC;
        end
        return s;
    endfunction

    // Circular search from rr_ptr; the first candidate found gets the one-hot grant.
    always_comb begin
        grant       = '0;
        rr_ptr_next = rr_ptr_reg;
        found       = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!found && cand[wrap_idx(int'(rr_ptr_reg), k)]) begin
                found = 1'b1;
                grant[wrap_idx(int'(rr_ptr_reg), k)] = 1'b1;
                if (wrap_idx(int'(rr_ptr_reg), k) == NUM_SRC - 1) begin
                    rr_ptr_next = '0;
                end else begin
                    rr_ptr_next = PTR_W'(wrap_idx(int'(rr_ptr_reg), k) + 1);
                end
            end
        end
    end

    always_comb begin
        int_next  = '0;
        exc_next  = '0;
        pc_next   = '0;
        inst_next = '0;
        core_next = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                int_next  = int_next  | int_arr[i];
                exc_next  = exc_next  | exc_arr[i];
                pc_next   = pc_next   | pc_arr[i];
                inst_next = inst_next | inst_arr[i];
                core_next = core_next | core_arr[i];
            end
        end
    end

    // The register can accept a new entry when empty or when its current entry leaves this cycle.
    assign ld_ok      = ~ovld_reg | ~sink_stall;
    assign out_enable = ovld_reg & ~sink_stall;
    assign src_ready  = grant & {NUM_SRC{ld_ok}};
    assign handshake  = found & ld_ok;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovld_reg           <= 1'b0;
            rr_ptr_reg         <= '0;
            evt_count_reg      <= '0;
            interrupt_reg      <= '0;
            exception_reg      <= '0;
            exception_pc_reg   <= '0;
            exception_inst_reg <= '0;
            coreid_reg         <= '0;
        end else begin
            if (handshake) begin
                ovld_reg           <= 1'b1;
                rr_ptr_reg         <= rr_ptr_next;
                interrupt_reg      <= int_next;
                exception_reg      <= exc_next;
                exception_pc_reg   <= pc_next;
                exception_inst_reg <= inst_next;
                coreid_reg         <= core_next;
            end else if (out_enable) begin
                ovld_reg <= 1'b0;
            end
            if (out_enable) begin
                evt_count_reg <= evt_count_reg + 32'd1;
            end
        end
    end

    assign out_interrupt      = interrupt_reg;
    assign out_exception      = exception_reg;
    assign out_exception_pc   = exception_pc_reg;
    assign out_exception_inst = exception_inst_reg;
    assign out_coreid         = coreid_reg;
    assign evt_count          = evt_count_reg;

`ifndef SYNTHESIS
    assert property (@(posedge clock) disable iff (!reset_n) $onehot0(grant));
    assert property (@(posedge clock) disable iff (!reset_n) (src_valid == '0) |-> (src_ready == '0));
`endif

endmodule

// File: tb/tb_arch_event_arbiter.sv
// Self-checking bench for arch_event_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_arch_event_arbiter;

    localparam int NS = 2;

    typedef struct packed {
        logic [31:0] intr;
        logic [31:0] exc;
        logic [63:0] pc;
        logic [31:0] inst;
        logic [7:0]  core;
    } ev_t;

    logic              clock;
    logic              reset_n;
    logic [NS-1:0]     src_valid;
    logic [NS-1:0]     src_ready;
    logic [32*NS-1:0]  src_interrupt;
    logic [32*NS-1:0]  src_exception;
    logic [64*NS-1:0]  src_exception_pc;
    logic [32*NS-1:0]  src_exception_inst;
    logic [8*NS-1:0]   src_coreid;
    logic              sink_stall;
    logic              out_enable;
    logic [31:0]       out_interrupt;
    logic [31:0]       out_exception;
    logic [63:0]       out_exception_pc;
    logic [31:0]       out_exception_inst;
    logic [7:0]        out_coreid;
    logic [31:0]       evt_count;

    ev_t src_ev [NS];
    ev_t out_ev;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_ovld;
    int          m_ptr;
    logic [31:0] m_count;
    ev_t         m_slot;
    logic [NS-1:0] exp_ready;
    bit          exp_oen;
    int          exp_hs;

    arch_event_arbiter #(.NUM_SRC(NS), .PTR_W(3)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .src_valid(src_valid),
        .src_ready(src_ready),
        .src_interrupt(src_interrupt),
        .src_exception(src_exception),
        .src_exception_pc(src_exception_pc),
        .src_exception_inst(src_exception_inst),
        .src_coreid(src_coreid),
        .sink_stall(sink_stall),
        .out_enable(out_enable),
        .out_interrupt(out_interrupt),
        .out_exception(out_exception),
        .out_exception_pc(out_exception_pc),
        .out_exception_inst(out_exception_inst),
        .out_coreid(out_coreid),
        .evt_count(evt_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            src_interrupt[32*i +: 32]      = src_ev[i].intr;
            src_exception[32*i +: 32]      = src_ev[i].exc;
            src_exception_pc[64*i +: 64]   = src_ev[i].pc;
            src_exception_inst[32*i +: 32] = src_ev[i].inst;
            src_coreid[8*i +: 8]           = src_ev[i].core;
        end
    end

    assign out_ev = '{out_interrupt, out_exception, out_exception_pc, out_exception_inst, out_coreid};

    function automatic int pick_src();
        int idx;
`ifdef ARCH_EVENT_INT_PRIO_EN
        for (int i = 0; i < NS; i++) begin
            idx = (m_ptr + i) % NS;
            if (src_valid[idx] && src_ev[idx].intr != 0) return idx;
        end
`endif
        for (int i = 0; i < NS; i++) begin
            idx = (m_ptr + i) % NS;
            if (src_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ovld  = 0;
        m_ptr   = 0;
        m_count = 0;
        m_slot  = '0;
    endtask

    task automatic model_eval();
        int g;
        bit ldok;
        g       = pick_src();
        ldok    = !m_ovld || !sink_stall;
        exp_oen = m_ovld && !sink_stall;
        exp_hs  = (g >= 0 && ldok) ? g : -1;
        exp_ready = '0;
        if (exp_hs >= 0) exp_ready[exp_hs] = 1'b1;
    endtask

    task automatic model_commit();
        if (exp_oen) m_count = m_count + 32'd1;
        if (exp_hs >= 0) begin
            m_slot = src_ev[exp_hs];
            m_ovld = 1;
            m_ptr  = (exp_hs + 1) % NS;
        end else if (exp_oen) begin
            m_ovld = 0;
        end
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic advance();
        model_commit();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        src_valid  = '0;
        sink_stall = 1'b0;
        for (int i = 0; i < NS; i++) src_ev[i] = '0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        checks++; if (out_enable !== 1'b0) begin errors++; $display("FAIL reset_oen got=%0b exp=0", out_enable); end
        checks++; if (evt_count !== 32'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", evt_count); end
        checks++; if (src_ready !== '0) begin errors++; $display("FAIL reset_ready got=%b exp=0", src_ready); end
        checks++; if (out_ev !== '0) begin errors++; $display("FAIL reset_payload got=%h exp=0", out_ev); end
        $display("reset: oen=%0b count=%0d ready=%b", out_enable, evt_count, src_ready);
        advance();
    endtask

    task automatic test_single();
        src_ev[0] = '{32'd0, 32'd2, 64'h8000_0000, 32'h0010_0073, 8'd0};
        src_valid = 2'b01;
        settle();
        checks++; if (src_ready !== 2'b01) begin errors++; $display("FAIL single_ready got=%b exp=01", src_ready); end
        advance();
        src_valid = '0;
        settle();
        checks++; if (out_enable !== 1'b1) begin errors++; $display("FAIL single_oen got=%0b exp=1", out_enable); end
        checks++; if (out_exception_pc !== 64'h8000_0000) begin errors++; $display("FAIL single_pc got=%h exp=80000000", out_exception_pc); end
        checks++; if (out_exception !== 32'd2) begin errors++; $display("FAIL single_exc got=%0d exp=2", out_exception); end
        advance();
        settle();
        checks++; if (evt_count !== 32'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", evt_count); end
        checks++; if (out_enable !== 1'b0) begin errors++; $display("FAIL single_oen_after got=%0b exp=0", out_enable); end
        $display("single: pc=%h exc=%0d count=%0d", out_exception_pc, out_exception, evt_count);
        advance();
    endtask

    task automatic test_contention();
        logic [NS-1:0] er;
        logic [7:0]    ec;
        do_reset();
        src_ev[0].core = 8'h10;
        src_ev[1].core = 8'h11;
        for (int k = 0; k < 5; k++) begin
            src_valid = (k < 4) ? 2'b11 : 2'b00;
            settle();
            if (k < 4) begin
                er = (k % 2 == 0) ? 2'b01 : 2'b10;
                checks++; if (src_ready !== er) begin errors++; $display("FAIL contention_ready k=%0d got=%b exp=%b", k, src_ready, er); end
            end
            if (k >= 1) begin
                ec = ((k - 1) % 2 == 0) ? 8'h10 : 8'h11;
                checks++; if (out_enable !== 1'b1) begin errors++; $display("FAIL contention_oen k=%0d got=%0b exp=1", k, out_enable); end
                checks++; if (out_coreid !== ec) begin errors++; $display("FAIL contention_core k=%0d got=%h exp=%h", k, out_coreid, ec); end
            end
            $display("contention k=%0d ready=%b oen=%0b core=%h", k, src_ready, out_enable, out_coreid);
            advance();
        end
        settle();
        checks++; if (evt_count !== 32'd4) begin errors++; $display("FAIL contention_count got=%0d exp=4", evt_count); end
        advance();
    endtask

    task automatic test_stall();
        do_reset();
        src_ev[0] = '{32'd0, 32'd3, 64'h1000, 32'h13, 8'h20};
        src_ev[1] = '{32'd0, 32'd4, 64'h2000, 32'h33, 8'h21};
        src_valid = 2'b10;
        settle();
        checks++; if (src_ready !== 2'b10) begin errors++; $display("FAIL stall_hs_ready got=%b exp=10", src_ready); end
        advance();
        src_valid  = 2'b01;
        sink_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            checks++; if (out_enable !== 1'b0) begin errors++; $display("FAIL stall_oen k=%0d got=%0b exp=0", k, out_enable); end
            checks++; if (src_ready !== 2'b00) begin errors++; $display("FAIL stall_ready k=%0d got=%b exp=00", k, src_ready); end
            checks++; if (out_coreid !== 8'h21 || out_exception_pc !== 64'h2000) begin errors++; $display("FAIL stall_payload k=%0d got=%h/%h exp=21/2000", k, out_coreid, out_exception_pc); end
            $display("stall k=%0d oen=%0b ready=%b core=%h", k, out_enable, src_ready, out_coreid);
            advance();
        end
        sink_stall = 1'b0;
        settle();
        checks++; if (out_enable !== 1'b1 || out_coreid !== 8'h21) begin errors++; $display("FAIL stall_release got=%0b/%h exp=1/21", out_enable, out_coreid); end
        checks++; if (src_ready !== 2'b01) begin errors++; $display("FAIL stall_release_ready got=%b exp=01", src_ready); end
        advance();
        src_valid = '0;
        settle();
        checks++; if (out_enable !== 1'b1 || out_coreid !== 8'h20) begin errors++; $display("FAIL stall_next got=%0b/%h exp=1/20", out_enable, out_coreid); end
        advance();
        settle();
        checks++; if (out_enable !== 1'b0 || evt_count !== 32'd2) begin errors++; $display("FAIL stall_once got=%0b/%0d exp=0/2", out_enable, evt_count); end
        $display("stall done: count=%0d", evt_count);
        advance();
    endtask

    task automatic test_priority();
        int first;
        int other;
        logic [NS-1:0] er;
`ifdef ARCH_EVENT_INT_PRIO_EN
        first = 1;
`else
        first = 0;
`endif
        other = 1 - first;
        do_reset();
        src_ev[0] = '{32'd0, 32'd5, 64'h3000, 32'h0, 8'h30};
        src_ev[1] = '{32'd7, 32'd0, 64'h3100, 32'h0, 8'h31};
        src_valid = 2'b11;
        settle();
        er = '0; er[first] = 1'b1;
        checks++; if (src_ready !== er) begin errors++; $display("FAIL prio_first got=%b exp=%b", src_ready, er); end
        advance();
        src_valid = '0; src_valid[other] = 1'b1;
        settle();
        er = '0; er[other] = 1'b1;
        checks++; if (src_ready !== er) begin errors++; $display("FAIL prio_second got=%b exp=%b", src_ready, er); end
        checks++; if (out_coreid !== 8'(8'h30 + first)) begin errors++; $display("FAIL prio_core1 got=%h exp=%h", out_coreid, 8'(8'h30 + first)); end
        advance();
        src_valid = '0;
        settle();
        checks++; if (out_enable !== 1'b1 || out_coreid !== 8'(8'h30 + other)) begin errors++; $display("FAIL prio_core2 got=%0b/%h exp=1/%h", out_enable, out_coreid, 8'(8'h30 + other)); end
        $display("priority: first=%0d second=%0d", first, other);
        advance();
    endtask

    task automatic test_async_reset();
        do_reset();
        src_ev[0] = '{32'd0, 32'd9, 64'h4000, 32'h1, 8'h40};
        src_valid = 2'b01;
        settle();
        advance();
        src_ev[0] = '{32'd0, 32'd8, 64'h5000, 32'h2, 8'h41};
        settle();
        advance();
        src_valid  = '0;
        sink_stall = 1'b1;
        settle();
        checks++; if (out_coreid !== 8'h41 || evt_count !== 32'd1) begin errors++; $display("FAIL areset_pre got=%h/%0d exp=41/1", out_coreid, evt_count); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (out_ev !== '0) begin errors++; $display("FAIL areset_payload got=%h exp=0", out_ev); end
        checks++; if (evt_count !== 32'd0 || out_enable !== 1'b0 || src_ready !== '0) begin errors++; $display("FAIL areset_ctrl got=%0d/%0b/%b exp=0/0/00", evt_count, out_enable, src_ready); end
        @(negedge clock);
        reset_n    = 1'b1;
        sink_stall = 1'b0;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            settle();
            checks++; if (out_enable !== 1'b0 || evt_count !== 32'd0) begin errors++; $display("FAIL areset_after k=%0d got=%0b/%0d exp=0/0", k, out_enable, evt_count); end
            $display("async reset after k=%0d oen=%0b count=%0d", k, out_enable, evt_count);
            advance();
        end
    endtask

    task automatic test_random();
        bit pend [NS];
        do_reset();
        for (int i = 0; i < NS; i++) pend[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NS; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1;
                    src_ev[i].intr = ($urandom_range(0, 3) == 0) ? ($urandom | 32'd1) : 32'd0;
                    src_ev[i].exc  = $urandom;
                    src_ev[i].pc   = {$urandom, $urandom};
                    src_ev[i].inst = $urandom;
                    src_ev[i].core = 8'($urandom);
                end
                src_valid[i] = pend[i];
            end
            sink_stall = ($urandom_range(0, 3) == 0);
            settle();
            checks++; if (src_ready !== exp_ready) begin errors++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, src_ready, exp_ready); end
            checks++; if (out_enable !== exp_oen) begin errors++; $display("FAIL rand_oen c=%0d got=%0b exp=%0b", c, out_enable, exp_oen); end
            checks++; if (out_ev !== m_slot) begin errors++; $display("FAIL rand_payload c=%0d got=%h exp=%h", c, out_ev, m_slot); end
            checks++; if (evt_count !== m_count) begin errors++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, evt_count, m_count); end
            $display("rand c=%0d valid=%b stall=%0b ready=%b oen=%0b count=%0d", c, src_valid, sink_stall, src_ready, out_enable, evt_count);
            if (exp_hs >= 0) pend[exp_hs] = 0;
            advance();
        end
        src_valid = '0;
    endtask

    initial begin
        reset_n    = 1'b0;
        src_valid  = '0;
        sink_stall = 1'b0;
        for (int i = 0; i < NS; i++) src_ev[i] = '0;
        model_reset();
        @(negedge clock);
        test_reset();
        test_single();
        test_contention();
        test_stall();
        test_priority();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arch_event_arbiter.md
# arch_event_arbiter

Round-robin arbiter and output stage that shares one architectural-event difftest port among `NUM_SRC` requesters (per-core or per-hart event sources). It sits between the commit/trap logic and the difftest arch-event sink. Each cycle it accepts at most one event over a valid/ready handshake, registers it, and presents it with a one-cycle `out_enable` strobe. A sink-side stall input holds the output register. An event counter supports coverage and debug.

## Interface
Parameters:
- `NUM_SRC`, default 2: number of requesters, 1..8.
- `PTR_W`, default 3: round-robin pointer width; must satisfy 2^PTR_W ≥ NUM_SRC.

Ports (one clock; reset is asynchronous and active-low):
- `clock`  in  1: sole clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `src_valid`  in  NUM_SRC: per-source event valid.
- `src_ready`  out  NUM_SRC: per-source grant; the handshake completes when valid & ready.
- `src_interrupt`  in  32*NUM_SRC: interrupt cause. Source i occupies [32i+31:32i].
- `src_exception`  in  32*NUM_SRC: exception cause.
- `src_exception_pc`  in  64*NUM_SRC: trapping PC.
- `src_exception_inst`  in  32*NUM_SRC: trapping instruction.
- `src_coreid`  in  8*NUM_SRC: core id.
- `sink_stall`  in  1: sink cannot take an event this cycle.
- `out_enable`  out  1: one event delivered this cycle.
- `out_interrupt`, `out_exception`, `out_exception_inst`  out  32 each: registered event fields.
- `out_exception_pc`  out  64: registered event PC.
- `out_coreid`  out  8: registered event core id.
- `evt_count`  out  32: number of events delivered (`out_enable` cycles). Wraps at 2^32.

## Operation
- Output register: flag `ovld` plus the payload fields. It can load when `ld_ok = ~ovld | ~sink_stall`.
- `out_enable = ovld & ~sink_stall`. Payload outputs hold their values while `ovld` is set.
- Grant: combinational and one-hot. Search starts at `rr_ptr` and picks the first asserted `src_valid[i]` in circular order.
- `src_ready[i] = grant[i] & ld_ok`. `src_ready` is zero whenever no source is valid.
- On a handshake for source g:
  - the payload of g loads into the output register;
  - `ovld` is set to 1;
  - `rr_ptr` becomes (g+1) mod NUM_SRC.
- With no handshake and `out_enable` high, `ovld` clears. Otherwise `ovld` holds.
- `rr_ptr` changes only on a handshake. Stalls and idle cycles never move it.
- `evt_count` increments by 1 on each `out_enable` cycle and wraps from 0xFFFFFFFF to 0.
- Sources must hold valid and payload stable until granted. The arbiter never drops or duplicates an event.
- Reset, asynchronous, including mid-transfer:
  - `ovld`=0, `rr_ptr`=0, `evt_count`=0, all payload registers 0;
  - therefore `out_enable`=0 and `src_ready`=0.
  - An event held in the output register at reset is discarded.

## Timing
- Latency: handshake in cycle N → `out_enable` in cycle N+1, provided `sink_stall`=0 in N+1.
- Throughput: one event per cycle with no stall. Back-to-back handshakes are allowed because `ld_ok` is true when the current entry is leaving.
- `sink_stall` asserted while `ovld`=1: `out_enable`=0 and all `src_ready`=0. Payload is held.
- `sink_stall` asserted while `ovld`=0: the register may still load. Delivery waits until the stall drops.
- Simultaneous requests: exactly one grant per cycle. Every continuously-valid source is served within NUM_SRC handshakes, so there is no starvation.
- NUM_SRC=1: `rr_ptr` is constantly 0. The block degenerates to a one-entry pipeline register.

## Configuration
- `ARCH_EVENT_INT_PRIO_EN` defined:
  - the arbiter first considers only sources with `src_valid[i]` and a nonzero `src_interrupt` slice, in round-robin order from `rr_ptr`;
  - if none qualify, it falls back to plain round-robin over all valid sources;
  - the pointer-update rule is unchanged.
- Not defined: pure round-robin. Interrupt fields do not affect arbitration.

## Test plan
- Reset check: deassert `reset_n` after 3 cycles with all valids at 0 → `out_enable`=0, `evt_count`=0, `src_ready`=0, all payload outputs 0.
- Single source: src0 pc=0x8000_0000, exception=2 for one cycle → `src_ready[0]`=1 that cycle; next cycle `out_enable`=1, `out_exception_pc`=0x8000_0000, `out_exception`=2; `evt_count`=1.
- Contention (NUM_SRC=2): both valid continuously for 4 cycles from reset → grant order 0,1,0,1; four consecutive `out_enable` pulses with matching coreids; `evt_count`=4.
- Stall: handshake, then `sink_stall`=1 for 3 cycles → `out_enable`=0 and `src_ready`=0 for those cycles, payload stable; event delivered exactly once in the cycle stall drops.
- Priority (macro defined, `rr_ptr`=0): src0 exception=5, src1 interrupt=7, both valid → src1 granted first, then src0. Without the macro → src0 first.
- Async reset mid-stall with `ovld`=1 → outputs 0 immediately. After release, no `out_enable` until a new handshake.
